fp_add_arbiter: RTL and testbench

- Shares one fp_add instance among NREQ independent requesters.
- Each cycle, round-robin arbitration picks one valid request and registers its operands and rounding mode into the adder inputs.
- A tag pipeline tracks which requester owns each in-flight operation, so results and exception flags return to the correct requester.
- A flush/drain FSM lets the system quiesce the adder before a rounding-policy change or power-down.

---
 rtl/fp_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fp_add_arbiter.sv | 148 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared definitions for the fp_add arbiter: FSM states, fp_add flag bit positions
// and rounding-mode encodings common with fp_add.
package fp_arb_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } arb_state_t;

    // Bit positions within fp_add flags {ov, un, inv, inexact, done}
    localparam int FLAG_DONE    = 0;
    localparam int FLAG_INEXACT = 1;
    localparam int FLAG_INV     = 2;
    localparam int FLAG_UN      = 3;
    localparam int FLAG_OV      = 4;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RZ  = 3'd1;
    localparam logic [2:0] RM_RD  = 3'd2;
    localparam logic [2:0] RM_RU  = 3'd3;
    localparam logic [2:0] RM_RNA = 3'd4;

    function automatic logic flags_exc(input logic [4:0] flags);
        return |flags[FLAG_OV:FLAG_INEXACT];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last winner, grants one
// requester per cycle and moves its pointer only when a grant is issued.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_vld
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (enable && !grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_vld  = 1'b1;
            end
        end
    end

    // A grant always lands on a set request bit, so a grant is a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (grant_vld) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fp_add among NREQ requesters with round-robin issue, a tag pipeline
// routing results back, and a flush/drain FSM. Define FP_ADD_ARB_PERF_EN for perf counters.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int ADD_LAT = 2,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FP_ADD_ARB_PERF_EN
    input  logic              perf_clr,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_exc_cnt,
`endif
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_rm,
    input  logic              flush,
    output logic              drained,
    output logic [W-1:0]      add_in1,
    output logic [W-1:0]      add_in2,
    output logic [2:0]        add_round_m,
    output logic              add_enable,
    input  logic [W-1:0]      add_out,
    input  logic [4:0]        add_flags,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [4:0]        rsp_flags
);

    arb_state_t     state, state_nxt;
    logic           arb_en;
    logic           busy;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   sel_a, sel_b;
    logic [2:0]     sel_rm;
    logic [ADD_LAT:0] tag_vld;
    logic [IDW-1:0] tag_id [ADD_LAT+1];

    assign busy = |tag_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        drained   = 1'b0;
        arb_en    = 1'b0;
        case (state)
            ST_RUN: begin
                arb_en = !flush;
                if (flush) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                drained = !busy;
                if (!flush && !busy) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .enable    (arb_en),
        .req       (req_valid),
        .grant     (req_ready),
        .grant_id  (gnt_id),
        .grant_vld (gnt_vld)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_rm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_rm = req_rm[i*3 +: 3];
            end
        end
    end

    // Issue stage: operands hold when idle so fp_add sees stable inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_in1     <= '0;
            add_in2     <= '0;
            add_round_m <= RM_RNE;
            add_enable  <= 1'b0;
        end else begin
            add_enable <= gnt_vld;
            if (gnt_vld) begin
                add_in1     <= sel_a;
                add_in2     <= sel_b;
                add_round_m <= sel_rm;
            end
        end
    end

    // Tag pipeline: stage j tracks the op issued j edges ago; stage ADD_LAT meets add_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int j = 0; j <= ADD_LAT; j++) tag_id[j] <= '0;
        end else begin
            tag_vld   <= {tag_vld[ADD_LAT-1:0], gnt_vld};
            tag_id[0] <= gnt_id;
            for (int j = 1; j <= ADD_LAT; j++) tag_id[j] <= tag_id[j-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_vld[ADD_LAT]) rsp_valid[tag_id[ADD_LAT]] = 1'b1;
    end

    assign rsp_data  = add_out;
    assign rsp_flags = add_flags;

`ifdef FP_ADD_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt <= '0;
            perf_exc_cnt   <= '0;
        end else if (perf_clr) begin
            perf_issue_cnt <= '0;
            perf_exc_cnt   <= '0;
        end else begin
            if (gnt_vld) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (tag_vld[ADD_LAT] && flags_exc(add_flags)) perf_exc_cnt <= perf_exc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural fp_add stand-in, reference arbiter/FSM model
// and a response scoreboard keyed by issue cycle.
module tb_fp_add_arbiter;
    import fp_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int ADD_LAT = 2;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_rm;
    logic              flush;
    logic              drained;
    logic [W-1:0]      add_in1, add_in2;
    logic [2:0]        add_round_m;
    logic              add_enable;
    logic [W-1:0]      add_out;
    logic [4:0]        add_flags;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [4:0]        rsp_flags;
`ifdef FP_ADD_ARB_PERF_EN
    logic              perf_clr = 1'b0;
    logic [31:0]       perf_issue_cnt, perf_exc_cnt;
`endif

    always #5 clk = ~clk;

    fp_add_arbiter #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
`ifdef FP_ADD_ARB_PERF_EN
        .perf_clr(perf_clr), .perf_issue_cnt(perf_issue_cnt), .perf_exc_cnt(perf_exc_cnt),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_rm(req_rm), .flush(flush), .drained(drained), .add_in1(add_in1),
        .add_in2(add_in2), .add_round_m(add_round_m), .add_enable(add_enable),
        .add_out(add_out), .add_flags(add_flags), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in fp_add: returns {result, ov, un, inv, inexact}; two known IEEE cases exact.
    function automatic logic [W+3:0] fa_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] rm);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 4'b0000};
        if (a == 32'h7F80_0000 && b == 32'hFF80_0000) return {32'h7FC0_0000, 4'b0010};
        return {a + b + W'(rm), 3'b000, a[0] ^ b[0]};
    endfunction

    logic [W+4:0] fa_s [ADD_LAT];
    always @(posedge clk) begin
        fa_s[0] <= {fa_res(add_in1, add_in2, add_round_m), add_enable};
        for (int j = 1; j < ADD_LAT; j++) fa_s[j] <= fa_s[j-1];
    end
    assign add_out   = fa_s[ADD_LAT-1][W+4:5];
    assign add_flags = fa_s[ADD_LAT-1][4:0];

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic [4:0]   flags;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           glog[$];
    exp_t         e_m;
    logic [W+3:0] r_m;
    arb_state_t   st_m = ST_RUN;
    int           ptr_m = NREQ - 1;
    int           cyc = 0;
    int           idx, hid, drn_cnt = 0;
    logic         hs, busy_m, last_hs = 1'b0;
    logic [NREQ-1:0] exp_ready;
    logic [W-1:0] exp_in1 = '0;
    int           iss_m = 0, exc_m = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            busy_m    = (sbq.size() != 0);
            exp_ready = '0;
            hs        = 1'b0;
            hid       = 0;
            if (st_m == ST_RUN && !flush) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (ptr_m + k) % NREQ;
                    if (!hs && req_valid[IDW'(idx)]) begin
                        hs = 1'b1;
                        hid = idx;
                        exp_ready[IDW'(idx)] = 1'b1;
                    end
                end
            end
            if (drained) drn_cnt++;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("drained", 64'(drained), 64'(st_m == ST_DRAIN && !busy_m));
            chk("add_enable", 64'(add_enable), 64'(last_hs));
            chk("add_in1", 64'(add_in1), 64'(exp_in1));
`ifdef FP_ADD_ARB_PERF_EN
            chk("perf_issue", 64'(perf_issue_cnt), 64'(iss_m));
            chk("perf_exc", 64'(perf_exc_cnt), 64'(exc_m));
`endif
            if (busy_m && (cyc - sbq[0].cyc) == ADD_LAT + 1) begin
                e_m = sbq.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << e_m.id));
                chk("rsp_data", 64'(rsp_data), 64'(e_m.data));
                chk("rsp_flags", 64'(rsp_flags), 64'(e_m.flags));
                if (|e_m.flags[4:1]) exc_m++;
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'(0));
            end
            if (st_m == ST_RUN) begin
                if (flush) st_m = ST_DRAIN;
            end else if (!flush && !busy_m) begin
                st_m = ST_RUN;
            end
            if (hs) begin
                r_m      = fa_res(req_a[hid*W +: W], req_b[hid*W +: W], req_rm[hid*3 +: 3]);
                e_m.id    = hid;
                e_m.data  = r_m[W+3:4];
                e_m.flags = {r_m[3:0], 1'b1};
                e_m.cyc   = cyc;
                sbq.push_back(e_m);
                glog.push_back(hid);
                ptr_m   = hid;
                exp_in1 = req_a[hid*W +: W];
                iss_m++;
            end
            last_hs = hs;
`ifdef FP_ADD_ARB_PERF_EN
            if (perf_clr) begin
                iss_m = 0;
                exc_m = 0;
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] rm);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_rm[i*3 +: 3] = rm;
        req_valid[IDW'(i)] = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        sbq.delete();
        ptr_m   = NREQ - 1;
        st_m    = ST_RUN;
        last_hs = 1'b0;
        exp_in1 = '0;
        iss_m   = 0;
        exc_m   = 0;
        repeat (cycles) begin
            @(negedge clk);
            chk("rst_in1", 64'(add_in1), 64'(0));
            chk("rst_in2", 64'(add_in2), 64'(0));
            chk("rst_rm", 64'(add_round_m), 64'(0));
            chk("rst_enable", 64'(add_enable), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_drained", 64'(drained), 64'(0));
            chk("rst_ready", 64'(req_ready), 64'(0));
        end
        tick();
        rst = 1'b1;
    endtask

    int exp_g[6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_rm    = '0;
        flush     = 1'b0;
        do_reset(2);

        // single op 1.0 + 2.0
        set_req(0, 32'h3F80_0000, 32'h4000_0000, RM_RNE);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // contention among 0, 1, 3 from a freshly reset pointer
        do_reset(1);
        glog.delete();
        for (int c = 0; c < 6; c++) begin
            set_req(0, $urandom, $urandom, 3'($urandom_range(0, 4)));
            set_req(1, $urandom, $urandom, 3'($urandom_range(0, 4)));
            set_req(3, $urandom, $urandom, 3'($urandom_range(0, 4)));
            tick();
        end
        req_valid = '0;
        chk("grant_count", 64'(glog.size()), 64'(6));
        for (int j = 0; j < glog.size() && j < 6; j++) chk("grant_order", 64'(glog[j]), 64'(exp_g[j]));
        repeat (6) tick();

        // +inf + -inf from requester 2
        set_req(2, 32'h7F80_0000, 32'hFF80_0000, RM_RZ);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // streaming requester 1 interrupted by a 5-cycle flush
        drn_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            set_req(1, $urandom, $urandom, RM_RU);
            flush = (c >= 3 && c < 8);
            tick();
        end
        req_valid = '0;
        flush = 1'b0;
        chk("drained_seen", 64'(drn_cnt > 0), 64'(1));
        repeat (6) tick();

        // flush while already empty
        flush = 1'b1;
        repeat (3) tick();
        flush = 1'b0;
        repeat (3) tick();

        // random traffic with occasional flush
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*W +: W]  = $urandom;
                req_b[i*W +: W]  = $urandom;
                req_rm[i*3 +: 3] = 3'($urandom_range(0, 4));
            end
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            flush     = ($urandom_range(0, 9) == 0);
            tick();
        end
        req_valid = '0;
        flush     = 1'b0;
        repeat (6) tick();

        // reset one cycle after a handshake; the op must never respond
        set_req(2, 32'h1234_5678, 32'h0000_0011, RM_RD);
        tick();
        req_valid = '0;
        do_reset(2);
        repeat (6) tick();
        set_req(0, 32'h10, 32'h20, RM_RNE);
        set_req(1, 32'h30, 32'h40, RM_RNE);
        tick();
        tick();
        req_valid = '0;
        repeat (6) tick();

`ifdef FP_ADD_ARB_PERF_EN
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            set_req(0, 32'h100 + 32'(i * 2), (i == 3 || i == 7) ? 32'h1 : 32'h2, RM_RNE);
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        chk("perf_issue_10", 64'(perf_issue_cnt), 64'(10));
        chk("perf_exc_2", 64'(perf_exc_cnt), 64'(2));
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        tick();
        chk("perf_clr_issue", 64'(perf_issue_cnt), 64'(0));
        chk("perf_clr_exc", 64'(perf_exc_cnt), 64'(0));
`endif

        repeat (4) tick();
        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
